// File: rtl/proc_pkg.sv
// Shared definitions for the five-bit-opcode MIPS-style processor: opcodes,
// instruction field positions, fetch FSM states and defaults.
package proc_pkg;

  localparam int          ADDR_W_DEF = 12;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0000;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  localparam int RD_MSB    = 26;
  localparam int RD_LSB    = 22;
  localparam int RS_MSB    = 21;
  localparam int RS_LSB    = 17;
  localparam int RT_MSB    = 16;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_MSB = 11;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_MSB = 6;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_MSB   = 16;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 26;
  localparam int TGT_LSB   = 0;

  typedef enum logic [0:0] {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer: a registered output slot plus one skid slot.
// Empty slots hold EMPTY so the outputs never show stale payloads.
module fetch_skid_buf #(
  parameter int           W     = 8,
  parameter logic [W-1:0] EMPTY = {W{1'b0}}
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_skid_valid
);

  logic         r_out_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_out_data;
  logic [W-1:0] r_skid_data;
  logic         w_out_free;

  // The output slot can take new data when empty or when it is leaving this cycle.
  assign w_out_free = ~r_out_valid | (r_out_valid & i_ready);

  // Slot update: skid drains to the output first, so order is preserved.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= EMPTY;
      r_skid_data  <= EMPTY;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= i_push;
        r_skid_data  <= i_push ? i_push_data : EMPTY;
      end else begin
        r_out_valid  <= i_push;
        r_out_data   <= i_push ? i_push_data : EMPTY;
      end
    end else if (i_push) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_push_data;
    end
  end

  assign o_valid      = r_out_valid;
  assign o_data       = r_out_data;
  assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the synchronous instruction memory and hands
// instructions to decode in program order, with redirect support from execute.
module instruction_fetch
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [31:0]       NOP      = NOP_INSN
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_insn,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1
);

  localparam int                PAY_W     = 32 + 2 * ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PAY_W-1:0]  EMPTY_PAY = {NOP, {ADDR_W{1'b0}}, PC_ONE};

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic              w_run;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              r_kill;
  logic              w_redirect;
  logic              w_deq;
  logic              w_issue;
  logic              w_push;
  logic              w_skid_valid;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_after;
  logic [PAY_W-1:0]  w_push_data;
  logic [PAY_W-1:0]  w_out_data;

  // Fetch state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE lasts only while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    case (r_state)
      FS_IDLE: w_state_next = FS_RUN;
      FS_RUN:  w_run        = 1'b1;
      default: w_state_next = FS_IDLE;
    endcase
  end

  // The in-flight read already counts as an occupied slot, capping outstanding work at two.
  assign w_redirect  = w_run & redirect_valid;
  assign w_deq       = if_valid & if_ready;
  assign w_occ       = {1'b0, if_valid} + {1'b0, w_skid_valid} + {1'b0, r_inflight};
  assign w_occ_after = w_occ - {1'b0, w_deq};
  assign w_issue     = w_run & ~reset & ~redirect_valid & (w_occ_after < 2'd2);
  assign w_push      = r_inflight & ~r_kill;
  assign w_push_data = {imem_q, r_inflight_pc, r_inflight_pc + PC_ONE};

  assign imem_rd   = w_issue;
  assign imem_addr = r_pc;

  // PC and in-flight tracking; a redirect replaces the PC and squashes the pending read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= w_redirect & r_inflight;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end
      if (w_redirect) begin
        r_pc <= redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + PC_ONE;
      end
    end
  end

  fetch_skid_buf #(
    .W     (PAY_W),
    .EMPTY (EMPTY_PAY)
  ) u_skid (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_flush      (w_redirect),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_ready      (if_ready),
    .o_valid      (if_valid),
    .o_data       (w_out_data),
    .o_skid_valid (w_skid_valid)
  );

  assign {if_insn, if_pc, if_pc_plus1} = w_out_data;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-bit-opcode MIPS-style processor. It owns the program counter, drives the synchronous instruction memory, and presents one instruction per cycle to decode over a valid/ready handshake. It absorbs one cycle of memory read latency with a one-entry skid buffer, and accepts PC redirects (branch, jump, jal, jr, bex) from execute, discarding wrong-path fetches.

## Interface
- ADDR_W, 12: PC / imem word-address width (4096 words).
- RESET_PC, 0: PC value loaded on reset.
- NOP, 32'h0000_0000: value driven on if_insn while if_valid is low.

- clock  in  1  single clock for the stage; everything is posedge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- imem_rd  out  1  read strobe; imem_q returns the data on the following cycle.
- imem_addr  out  ADDR_W  word address of the read.
- imem_q  in  32  read data, valid the cycle after imem_rd.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  ADDR_W  new PC (already resolved: PC+1+N, target, or $rd).
- if_ready  in  1  decode accepts if_insn this cycle.
- if_valid  out  1  if_insn/if_pc hold a live instruction.
- if_insn  out  32  instruction word.
- if_pc  out  ADDR_W  address of if_insn.
- if_pc_plus1  out  ADDR_W  if_pc+1 modulo 2^ADDR_W (jal link value, branch base).

## Operation
- States: IDLE (reset asserted) and RUN. reset → IDLE; first edge with reset low → RUN. RUN never returns to IDLE except by reset.
- Storage: pc, output register (out_valid), skid register (skid_valid), inflight flag, kill flag.
- occ = out_valid + skid_valid + inflight. A read is issued when in RUN, no redirect, and occ − (if_valid & if_ready) < 2. On issue: imem_addr = pc, imem_rd = 1, pc ← pc+1 (wraps 2^ADDR_W−1 → 0), inflight ← 1.
- Returning data, when inflight and not killed: goes to the output register if it is empty or is being consumed this cycle; otherwise goes to skid. When the output is consumed and skid is full, skid moves to output.
- Ordering is strictly program order; no instruction is dropped or duplicated under backpressure.
- Redirect (redirect_valid = 1 in RUN): pc ← redirect_pc; out_valid and skid_valid are cleared; any inflight read is marked killed and its data is discarded next cycle. No read is issued in the redirect cycle. An instruction handshaken in the same cycle (if_valid & if_ready) counts as delivered. A redirect overrides backpressure.
- Reset has priority over redirect and over all handshakes.

## Timing
- Reset values: imem_rd 0, imem_addr RESET_PC, if_valid 0, if_insn NOP, if_pc 0, if_pc_plus1 1, pc RESET_PC, inflight/kill/skid_valid 0.
- Cycle 0 is the first edge with reset low: imem_rd = 1 for RESET_PC in cycle 1. The first if_valid appears in cycle 2.
- Steady state with if_ready high: one instruction per cycle, 2-cycle fetch latency.
- Redirect sampled at edge t: imem_rd for redirect_pc at t+1, if_valid for it at t+2. The bubble is 2 cycles.
- if_ready low: if_valid, if_insn and if_pc hold stable. At most 2 instructions are outstanding, after which imem_rd is 0.
- Outputs are registered; there is no combinational path from if_ready or redirect_* to if_*. imem_rd depends combinationally on if_ready and redirect_valid.
- Back-to-back redirects: the last one wins; no killed data ever reaches if_valid.

## Structure
- Shared package (proc_pkg): opcode constants (ADD/ALU 00000, J 00001, BNE 00010, JAL 00011, JR 00100, ADDI 00101, BLT 00110, SW 00111, LW 01000, SETX 10101, BEX 10110), instruction field positions, NOP, default ADDR_W.
- One sub-module: fetch_skid_buf, a 2-entry in-order buffer (output plus skid) with flush, valid/ready out, and push in.

## Test plan
- Sequential fetch: imem[0..3] = 28400005, 28800003, 00C22000, 28C60000; if_ready = 1 after reset → if_pc 0,1,2,3 on cycles 2–5 with matching if_insn, and if_pc_plus1 = if_pc+1.
- Backpressure: if_ready low for 3 cycles while if_pc = 2 → if_insn stays 00C22000, imem_rd drops after 2 outstanding reads, and the resumed stream is 2,3,4 with no gap or duplicate.
- Jump: imem[4] = 0800000E; execute asserts redirect_valid with redirect_pc = 14 at edge t → reads for 5 and 6 are discarded, and the next if_valid has if_pc = 14 at t+2.
- Redirect during stall: if_ready low, skid full, redirect_pc = 49 → both buffered entries are dropped, and the next delivered if_pc is 49, then 50.
- Wrap: RESET_PC = 4095 → delivered if_pc sequence is 4095, 0, 1; if_pc_plus1 for 4095 is 0.
- Reset mid-stream: assert reset with 2 outstanding instructions → next cycle if_valid = 0 and if_insn = NOP; after release, fetch restarts at RESET_PC with 2-cycle latency.
